// File: rtl/x_top_pkg.sv
// Shared definitions for the UART memory-link server: command bytes,
// frame FSM states and the byte-counter width.
package x_top_pkg;

    localparam logic [7:0] CMD_READ  = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] ACK_WRITE = 8'hA5;

    localparam int unsigned BCNT_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        MEM,
        RESP
    } state_t;

endpackage

// File: rtl/x_top_uart.sv
// 8N1 serial byte receiver and transmitter, LSB first. The bit period is
// p_clk_hz/p_baud clocks; the receiver samples at mid-bit and rejects starts
// that are no longer low at half a bit.
module x_top_uart
    import x_top_pkg::*;
#(
    parameter int unsigned p_clk_hz = 12000000,
    parameter int unsigned p_baud   = 9600
) (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic       i_rx,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_valid,
    output logic       o_rx_ferr,
    input  logic [7:0] i_tx_byte,
    input  logic       i_tx_start,
    output logic       o_tx_busy,
    output logic       o_tx
);

    localparam int unsigned BIT_CLKS  = p_clk_hz / p_baud;
    localparam int unsigned HALF_CLKS = BIT_CLKS / 2;
    localparam int unsigned CW        = $clog2(BIT_CLKS + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CLKS - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    logic [2:0]    r_rx_sync;
    logic          w_rx;
    logic          w_rx_fall;
    rx_state_t     r_rx_state;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bits;
    logic [7:0]    r_rx_sh;
    logic [7:0]    r_rx_byte;
    logic          r_rx_valid;
    logic          r_rx_ferr;

    logic          r_tx_busy;
    logic          r_tx;
    logic [CW-1:0] r_tx_cnt;
    logic [3:0]    r_tx_bits;
    logic [8:0]    r_tx_sh;

    assign w_rx      = r_rx_sync[1];
    assign w_rx_fall = r_rx_sync[2] & ~r_rx_sync[1];

    assign o_rx_byte  = r_rx_byte;
    assign o_rx_valid = r_rx_valid;
    assign o_rx_ferr  = r_rx_ferr;
    assign o_tx_busy  = r_tx_busy;
    assign o_tx       = r_tx;

    // Two-flop synchroniser for the serial input plus one delayed copy for edge detection
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) r_rx_sync <= '1;
        else         r_rx_sync <= {r_rx_sync[1:0], i_rx};
    end

    // Receive state machine: start qualification, mid-bit data sampling, stop check
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bits  <= '0;
            r_rx_sh    <= '0;
            r_rx_byte  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_state <= RX_START;
                        r_rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == HALF_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_bits  <= '0;
                        r_rx_state <= w_rx ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt  <= '0;
                        r_rx_sh   <= {w_rx, r_rx_sh[7:1]};
                        r_rx_bits <= r_rx_bits + 3'd1;
                        if (r_rx_bits == 3'd7) r_rx_state <= RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_IDLE;
                        if (w_rx) begin
                            r_rx_byte  <= r_rx_sh;
                            r_rx_valid <= 1'b1;
                        end else begin
                            r_rx_ferr <= 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // Transmit shifter: start bit driven on accept, then 8 data bits and the stop bit
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_tx_busy <= 1'b0;
            r_tx      <= 1'b1;
            r_tx_cnt  <= '0;
            r_tx_bits <= '0;
            r_tx_sh   <= '1;
        end else if (!r_tx_busy) begin
            if (i_tx_start) begin
                r_tx_busy <= 1'b1;
                r_tx      <= 1'b0;
                r_tx_sh   <= {1'b1, i_tx_byte};
                r_tx_cnt  <= '0;
                r_tx_bits <= '0;
            end
        end else if (r_tx_cnt == BIT_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_bits == 4'd9) begin
                r_tx_busy <= 1'b0;
                r_tx      <= 1'b1;
            end else begin
                r_tx      <= r_tx_sh[0];
                r_tx_sh   <= {1'b1, r_tx_sh[8:1]};
                r_tx_bits <= r_tx_bits + 4'd1;
            end
        end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/x_top_uart_server.sv
// Far-end responder of the UART memory link: decodes request frames,
// performs one access on the word-memory bus and returns the response frame.
module x_top_uart_server
    import x_top_pkg::*;
#(
    parameter int unsigned p_clk_hz  = 12000000,
    parameter int unsigned p_baud    = 9600,
    parameter int unsigned p_timeout = 100000
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_rx,
    output logic        o_tx,
    output logic        o_valid,
    output logic        o_rnw,
    output logic [31:0] o_addr,
    output logic [31:0] o_data,
    input  logic [31:0] i_data,
    input  logic        i_accept
);

    localparam logic [31:0] TMO_LAST = 32'(p_timeout - 1);

    logic [7:0]        w_rx_byte;
    logic              w_rx_valid;
    logic              w_rx_ferr;
    logic              w_tx_busy;
    logic [31:0]       w_rd_shift;

    state_t            r_state;
    logic [BCNT_W-1:0] r_cnt;
    logic              r_done;
    logic              r_rnw;
    logic [31:0]       r_addr;
    logic [31:0]       r_data;
    logic              r_valid;
    logic [31:0]       r_rdata;
    logic [31:0]       r_tmo;
    logic [7:0]        r_tx_byte;
    logic              r_tx_start;

    x_top_uart #(
        .p_clk_hz (p_clk_hz),
        .p_baud   (p_baud)
    ) u_uart (
        .i_clk      (i_clk),
        .i_nrst     (i_nrst),
        .i_rx       (i_rx),
        .o_rx_byte  (w_rx_byte),
        .o_rx_valid (w_rx_valid),
        .o_rx_ferr  (w_rx_ferr),
        .i_tx_byte  (r_tx_byte),
        .i_tx_start (r_tx_start),
        .o_tx_busy  (w_tx_busy),
        .o_tx       (o_tx)
    );

    assign w_rd_shift = r_rdata >> {r_cnt, 3'b000};

    assign o_valid = r_valid;
    assign o_rnw   = r_rnw;
    assign o_addr  = r_addr;
    assign o_data  = r_data;

    // Frame FSM: command/address/data collection with inter-byte timeout,
    // memory handshake, then back-to-back response bytes
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_rnw      <= 1'b1;
            r_addr     <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_rdata    <= '0;
            r_tmo      <= '0;
            r_tx_byte  <= '0;
            r_tx_start <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tmo <= '0;
                    if (w_rx_valid && (w_rx_byte == CMD_READ || w_rx_byte == CMD_WRITE)) begin
                        r_rnw   <= (w_rx_byte == CMD_READ);
                        r_cnt   <= '0;
                        r_state <= ADDR;
                    end
                end
                ADDR: begin
                    if (w_rx_valid) begin
                        r_addr <= {w_rx_byte, r_addr[31:8]};
                        r_tmo  <= '0;
                        r_cnt  <= r_cnt + BCNT_W'(1);
                        if (r_cnt == '1) begin
                            if (r_rnw) begin
                                r_valid <= 1'b1;
                                r_state <= MEM;
                            end else begin
                                r_state <= DATA;
                            end
                        end
                    end else if (w_rx_ferr || r_tmo == TMO_LAST) begin
                        r_tmo   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_tmo <= r_tmo + 32'd1;
                    end
                end
                DATA: begin
                    if (w_rx_valid) begin
                        r_data <= {w_rx_byte, r_data[31:8]};
                        r_tmo  <= '0;
                        r_cnt  <= r_cnt + BCNT_W'(1);
                        if (r_cnt == '1) begin
                            r_valid <= 1'b1;
                            r_state <= MEM;
                        end
                    end else if (w_rx_ferr || r_tmo == TMO_LAST) begin
                        r_tmo   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_tmo <= r_tmo + 32'd1;
                    end
                end
                MEM: begin
                    if (r_valid && i_accept) begin
                        if (r_rnw) r_rdata <= i_data;
                        r_valid <= 1'b0;
                        r_cnt   <= '0;
                        r_done  <= 1'b0;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    // A start strobe in flight has not yet raised busy, so wait it out
                    if (!r_tx_start && !w_tx_busy) begin
                        if (r_done) begin
                            r_state <= IDLE;
                        end else begin
                            r_tx_start <= 1'b1;
                            r_tx_byte  <= r_rnw ? w_rd_shift[7:0] : ACK_WRITE;
                            r_cnt      <= r_cnt + BCNT_W'(1);
                            r_done     <= !r_rnw || (r_cnt == '1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_x_top_uart_server.sv
// Self-checking bench for x_top_uart_server at 10 clocks per bit.
module tb_x_top_uart_server;

    localparam int unsigned BITC = 10;

    typedef struct {
        bit          pre_en;
        logic [7:0]  pre;
        logic        rnw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int unsigned stall;
        bit          stray;
        int unsigned n_resp;
        logic [31:0] resp;
    } vec_t;

    typedef struct {
        logic        rnw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int unsigned stall;
    } req_t;

    logic        clk = 1'b0;
    logic        i_nrst;
    logic        i_rx;
    logic        o_tx;
    logic        o_valid;
    logic        o_rnw;
    logic [31:0] o_addr;
    logic [31:0] o_data;
    logic [31:0] i_data;
    logic        i_accept;

    req_t        mq[$];
    logic [7:0]  txq[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned tx_count = 0;
    bit          tx_drop  = 1'b0;
    bit          stray_acc = 1'b0;
    vec_t        vecs[5];

    always #5 clk = ~clk;

    x_top_uart_server #(
        .p_clk_hz  (1000000),
        .p_baud    (100000),
        .p_timeout (300)
    ) dut (
        .i_clk    (clk),
        .i_nrst   (i_nrst),
        .i_rx     (i_rx),
        .o_tx     (o_tx),
        .o_valid  (o_valid),
        .o_rnw    (o_rnw),
        .o_addr   (o_addr),
        .o_data   (o_data),
        .i_data   (i_data),
        .i_accept (i_accept)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stopv);
        @(negedge clk);
        i_rx = 1'b0;
        repeat (BITC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            repeat (BITC) @(negedge clk);
        end
        i_rx = stopv;
        repeat (BITC) @(negedge clk);
        i_rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata);
        logic [7:0] b;
        send_byte(rnw ? 8'h00 : 8'h01, 1'b1);
        for (int i = 0; i < 4; i++) begin
            b = addr[8*i +: 8];
            send_byte(b, 1'b1);
        end
        if (!rnw) begin
            for (int i = 0; i < 4; i++) begin
                b = wdata[8*i +: 8];
                send_byte(b, 1'b1);
            end
        end
    endtask

    task automatic expect_req(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int unsigned stall,
                              input int unsigned n_resp, input logic [31:0] resp);
        req_t r;
        r.rnw = rnw; r.addr = addr; r.wdata = wdata; r.rdata = rdata; r.stall = stall;
        mq.push_back(r);
        for (int i = 0; i < int'(n_resp); i++) txq.push_back(resp[8*i +: 8]);
    endtask

    task automatic wait_done(input string name);
        int unsigned n = 0;
        while ((mq.size() != 0 || txq.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (mq.size() != 0 || txq.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d requests and %0d bytes outstanding, required 0",
                     name, mq.size(), txq.size());
            mq.delete();
            txq.delete();
        end
        repeat (20) @(negedge clk);
    endtask

    // Memory model: checks the request against the scoreboard and accepts after the stall count
    initial begin
        bit          acc_pending = 1'b0;
        int unsigned wait_cnt = 0;
        i_accept = 1'b0;
        i_data   = '0;
        forever begin
            @(negedge clk);
            if (acc_pending) begin
                i_accept    = 1'b0;
                acc_pending = 1'b0;
                chk("valid_drop", {31'b0, o_valid}, 32'd0);
            end else if (o_valid === 1'b1) begin
                if (mq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_req: got rnw=%0b addr=0x%08h, required no request", o_rnw, o_addr);
                    i_accept = 1'b0;
                    while (o_valid === 1'b1) @(negedge clk);
                end else begin
                    chk("mem_rnw", {31'b0, o_rnw}, {31'b0, mq[0].rnw});
                    chk("mem_addr", o_addr, mq[0].addr);
                    if (!mq[0].rnw) chk("mem_wdata", o_data, mq[0].wdata);
                    if (wait_cnt == mq[0].stall) begin
                        i_accept    = 1'b1;
                        i_data      = mq[0].rdata;
                        acc_pending = 1'b1;
                        wait_cnt    = 0;
                        void'(mq.pop_front());
                    end else begin
                        i_accept = 1'b0;
                        wait_cnt++;
                    end
                end
            end else begin
                i_accept = stray_acc;
                i_data   = 32'hBAD0BAD0;
            end
        end
    end

    // Serial monitor on o_tx: decodes each byte at mid-bit and compares with the scoreboard
    initial begin
        logic [7:0] b;
        logic       stopb;
        forever begin
            @(negedge clk);
            if (o_tx === 1'b0) begin
                repeat (BITC/2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BITC) @(negedge clk);
                    b[i] = o_tx;
                end
                repeat (BITC) @(negedge clk);
                stopb = o_tx;
                if (tx_drop) begin
                    tx_drop = 1'b0;
                end else if (txq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_tx: got byte 0x%02h, required none", b);
                end else begin
                    chk("tx_byte", {24'b0, b}, {24'b0, txq.pop_front()});
                    chk("tx_stop", {31'b0, stopb}, 32'd1);
                end
                tx_count++;
            end
        end
    end

    initial begin
        int unsigned base;
        int unsigned n;

        vecs[0] = '{pre_en:1'b0, pre:8'h00, rnw:1'b0, addr:32'h0000_0010, wdata:32'hDEAD_BEEF,
                    rdata:32'h0, stall:3, stray:1'b0, n_resp:1, resp:32'h0000_00A5};
        vecs[1] = '{pre_en:1'b0, pre:8'h00, rnw:1'b1, addr:32'h0000_0010, wdata:32'h0,
                    rdata:32'hDEAD_BEEF, stall:0, stray:1'b0, n_resp:4, resp:32'hDEAD_BEEF};
        vecs[2] = '{pre_en:1'b1, pre:8'h7F, rnw:1'b1, addr:32'h0000_0004, wdata:32'h0,
                    rdata:32'h1234_5678, stall:1, stray:1'b1, n_resp:4, resp:32'h1234_5678};
        vecs[3] = '{pre_en:1'b0, pre:8'h00, rnw:1'b0, addr:32'h8000_0003, wdata:32'h0000_0000,
                    rdata:32'h0, stall:0, stray:1'b0, n_resp:1, resp:32'h0000_00A5};
        vecs[4] = '{pre_en:1'b1, pre:8'hA5, rnw:1'b1, addr:32'hFFFF_FFFF, wdata:32'h0,
                    rdata:32'hA5A5_005A, stall:5, stray:1'b0, n_resp:4, resp:32'hA5A5_005A};

        i_nrst = 1'b0;
        i_rx   = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_tx", {31'b0, o_tx}, 32'd1);
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_rnw", {31'b0, o_rnw}, 32'd1);
        chk("rst_addr", o_addr, 32'h0);
        chk("rst_data", o_data, 32'h0);
        i_nrst = 1'b1;
        repeat (10) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            expect_req(vecs[v].rnw, vecs[v].addr, vecs[v].wdata, vecs[v].rdata,
                       vecs[v].stall, vecs[v].n_resp, vecs[v].resp);
            stray_acc = vecs[v].stray;
            if (vecs[v].pre_en) send_byte(vecs[v].pre, 1'b1);
            send_frame(vecs[v].rnw, vecs[v].addr, vecs[v].wdata);
            wait_done("vec_done");
            stray_acc = 1'b0;
        end

        // Partial write abandoned by the inter-byte timeout, then a clean read
        expect_req(1'b1, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 0, 4, 32'hCAFE_F00D);
        send_byte(8'h01, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (400) @(negedge clk);
        send_frame(1'b1, 32'h0000_0020, 32'h0);
        wait_done("timeout_done");

        // Short low glitch inside the address field must not become a byte
        expect_req(1'b1, 32'h0000_0104, 32'h0, 32'h0BAD_F00D, 2, 4, 32'h0BAD_F00D);
        send_byte(8'h00, 1'b1);
        send_byte(8'h04, 1'b1);
        i_rx = 1'b0;
        repeat (3) @(negedge clk);
        i_rx = 1'b1;
        repeat (120) @(negedge clk);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_done("glitch_done");

        // Byte with a low stop bit mid-frame aborts the frame
        expect_req(1'b1, 32'h0000_0008, 32'h0, 32'h0102_0304, 0, 4, 32'h0102_0304);
        send_byte(8'h01, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h55, 1'b0);
        repeat (20) @(negedge clk);
        send_frame(1'b1, 32'h0000_0008, 32'h0);
        wait_done("ferr_done");

        // Reset during the second response byte
        expect_req(1'b1, 32'h0000_0040, 32'h0, 32'h1122_3344, 0, 4, 32'h1122_3344);
        base = tx_count;
        send_frame(1'b1, 32'h0000_0040, 32'h0);
        n = 0;
        while (tx_count < base + 1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_wait_byte1", tx_count, base + 1);
        repeat (40) @(negedge clk);
        tx_drop = 1'b1;
        i_nrst  = 1'b0;
        #1;
        chk("midrst_tx", {31'b0, o_tx}, 32'd1);
        chk("midrst_valid", {31'b0, o_valid}, 32'd0);
        chk("midrst_rnw", {31'b0, o_rnw}, 32'd1);
        chk("midrst_addr", o_addr, 32'h0);
        txq.delete();
        mq.delete();
        repeat (5) @(negedge clk);
        i_nrst = 1'b1;
        repeat (150) @(negedge clk);
        expect_req(1'b0, 32'h0000_0044, 32'h5A5A_1234, 32'h0, 1, 1, 32'h0000_00A5);
        send_frame(1'b0, 32'h0000_0044, 32'h5A5A_1234);
        wait_done("post_rst_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/x_top_uart_server.md
Name: x_top_uart_server

Overview:
- Far-end responder for the core's UART memory link: receives request frames on a serial line, performs the access on a local word-memory bus, returns the response frame on serial.
- Sits on the memory/host side and pairs with the core-side memory bridge that serialises core valid/accept accesses.
- Contains the frame FSM, inter-byte timeout and memory-bus initiator. Bit-level serial timing lives in one sub-module.

Parameters:
- p_clk_hz, 12000000, clock frequency in Hz.
- p_baud, 9600, serial bit rate. Bit period is p_clk_hz/p_baud clocks, integer division.
- p_timeout, 100000, clocks allowed between received bytes of one frame before the frame is abandoned.

Ports:
- i_clk  in  1  clock
- i_nrst  in  1  asynchronous active-low reset
- i_rx  in  1  serial request line, 8N1, idle high
- o_tx  out  1  serial response line, 8N1, idle high
- o_valid  out  1  memory request valid
- o_rnw  out  1  1=read, 0=write
- o_addr  out  32  byte address
- o_data  out  32  write data
- i_data  in  32  read data, valid in the cycle i_accept=1
- i_accept  in  1  memory accepts the current request

Behaviour:
- Reset values: o_tx=1, o_valid=0, o_rnw=1, o_addr=0, o_data=0. FSM in IDLE, timeout counter 0.
- Serial format: 8N1, LSB first.
  - RX detects a falling edge, then re-checks the line at half-bit. If the line is high, the start is rejected as a glitch.
  - Data bits are sampled at mid-bit.
  - A stop bit of 0 is a framing error: the byte is dropped and the FSM returns to IDLE.
- Request frame:
  - Command byte: 0x00 = read, 0x01 = write.
  - Then 4 address bytes, LSB first.
  - Write only: 4 data bytes, LSB first.
- Response frame:
  - Read: 4 bytes of read data, LSB first.
  - Write: single byte 0xA5.
- FSM states:
  - IDLE: wait for a byte. 0x00/0x01 latches rnw and goes to ADDR. Any other value is discarded and the FSM stays in IDLE.
  - ADDR: shift in 4 bytes into o_addr[7:0] first. After byte 4, go to DATA if a write, else MEM.
  - DATA: shift in 4 bytes into o_data. After byte 4, go to MEM.
  - MEM: o_valid=1 with o_rnw/o_addr/o_data stable until the first cycle i_accept=1.
    - In that cycle, capture i_data for a read.
    - o_valid=0 from the next cycle; go to RESP.
    - i_accept while o_valid=0 is ignored.
  - RESP: transmit the response bytes back-to-back. Each byte starts the cycle after the TX sub-module reports idle. After the last stop bit completes, return to IDLE.
- Timeout:
  - The counter runs only in ADDR/DATA and clears on every received byte.
  - At count == p_timeout-1 the partial frame is dropped: IDLE, no memory access, no response.
  - No timeout in MEM (memory may stall indefinitely) or in RESP.
- Bytes received during MEM/RESP are discarded, because the link is half-duplex by protocol.
- Address is passed through unaligned; no alignment checks.
- A reset mid-frame, mid-access or mid-transmission returns immediately to the reset values. o_tx goes high, with no truncated-byte recovery.

Decomposition:
- Shared package x_top_pkg:
  - command constants CMD_READ=8'h00, CMD_WRITE=8'h01, ACK_WRITE=8'hA5.
  - FSM state enum {IDLE, ADDR, DATA, MEM, RESP}.
  - byte-count width (2 bits).
- Sub-module x_top_uart: parameterised by p_clk_hz/p_baud.
  - RX side: byte output plus a one-cycle valid strobe and a framing-error strobe.
  - TX side: byte input, start strobe, busy flag.

Test Plan (sim: p_clk_hz=1000000, p_baud=100000 so 10 clocks/bit, p_timeout=300):
- Write: send 01, 10 00 00 00, EF BE AD DE.
  - Expect one o_valid pulse with o_rnw=0, o_addr=0x00000010, o_data=0xDEADBEEF, accept after 3 stall cycles.
  - Expect tx byte 0xA5.
- Read: send 00, 10 00 00 00; memory returns 0xDEADBEEF with immediate accept.
  - Expect tx bytes EF BE AD DE in order, 10 clocks/bit.
  - Expect o_valid high exactly 1 cycle.
- Unknown command: send 0x7F then 00 04 00 00 00.
  - 0x7F is ignored; the following read of 0x00000004 completes normally.
- Timeout: send 01, 10 00, then 400 idle clocks, then a full read frame.
  - No write issued; read frame served correctly.
- Glitch/framing: a 3-clock low pulse on i_rx is ignored; a byte with stop bit 0 is dropped and the FSM returns to IDLE.
- Reset mid-response: assert i_nrst low during the 2nd read-response byte.
  - o_tx=1 and o_valid=0 immediately.
  - The next write frame is served.
